// File: rtl/cpu_types_pkg.sv
// Shared CPU/memory types: machine word and the RAM model's handshake state.
package cpu_types_pkg;
    typedef logic [31:0] word_t;
    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;
endpackage

// File: rtl/ram_arb_pkg.sv
// Types and width helpers for the RAM port arbiter.
package ram_arb_pkg;
    typedef enum logic {IDLE, BUSY} arb_state_t;

    localparam int NREQ_DEF  = 4;
    localparam int BURST_DEF = 2;

    // Index width that stays at least one bit for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/rr_picker.sv
// Rotating-priority encoder: first requester at or after rr_ptr, wrapping.
// Latency: purely combinational.
// Backpressure: none; any=0 when no request is present.
module rr_picker #(
    parameter int NREQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);
    // Scan from farthest to nearest so the nearest hit is written last.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % NREQ]) begin
                idx = IDX_W'((int'(rr_ptr) + k) % NREQ);
                any = 1'b1;
            end
        end
    end
endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin owner of the single RAM port, with locked bursts of up to BURST words.
// Latency: request seen in IDLE drives RAM strobes the next cycle; owner released on last ACCESS.
// Backpressure: req_wait=1 for everyone except the owner on an ACCESS cycle. RAM_ARB_PERF_EN adds grant_cnt.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int NREQ  = NREQ_DEF,
    parameter int BURST = BURST_DEF
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NREQ-1:0]            req_ren,
    input  logic [NREQ-1:0]            req_wen,
    input  logic [NREQ-1:0]            req_lock,
    input  logic [NREQ*32-1:0]         req_addr,
    input  logic [NREQ*32-1:0]         req_store,
    output cpu_types_pkg::word_t       req_load,
    output logic [NREQ-1:0]            req_wait,
    output logic [$clog2(NREQ)-1:0]    grant_id,
    output logic                       grant_vld,
    output logic                       arb_err,
`ifdef RAM_ARB_PERF_EN
    output logic [NREQ*32-1:0]         grant_cnt,
`endif
    output logic                       ramREN,
    output logic                       ramWEN,
    output cpu_types_pkg::word_t       ramaddr,
    output cpu_types_pkg::word_t       ramstore,
    input  cpu_types_pkg::word_t       ramload,
    input  cpu_types_pkg::ramstate_t   ramstate
);
    localparam int IDX_W = idx_width(NREQ);
    localparam int BW    = idx_width(BURST);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] owner, owner_nxt, rr_ptr, rr_ptr_nxt, next_ptr, pick_idx;
    logic [BW-1:0]    beat, beat_nxt;
    logic             pick_any, own_act, own_access;

    rr_picker #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
        .req    (req_ren | req_wen),
        .rr_ptr (rr_ptr),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign req_load   = ramload;
    assign own_act    = (state == BUSY) && (req_ren[owner] || req_wen[owner]);
    assign own_access = own_act && (ramstate == cpu_types_pkg::ACCESS);
    assign next_ptr   = (owner == IDX_W'(NREQ - 1)) ? '0 : owner + 1'b1;

    always_comb begin
        state_nxt  = state;
        owner_nxt  = owner;
        rr_ptr_nxt = rr_ptr;
        beat_nxt   = beat;
        ramREN     = 1'b0;
        ramWEN     = 1'b0;
        ramaddr    = '0;
        ramstore   = '0;
        req_wait   = '1;
        arb_err    = 1'b0;
        grant_vld  = (state == BUSY);
        grant_id   = (state == BUSY) ? owner : '0;
        unique case (state)
            IDLE: begin
                if (pick_any) begin
                    owner_nxt = pick_idx;
                    beat_nxt  = '0;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                arb_err = (ramstate == cpu_types_pkg::ERROR);
                if (!own_act) begin
                    state_nxt  = IDLE;
                    rr_ptr_nxt = next_ptr;
                end else begin
                    // Write wins when the owner raises both strobes.
                    ramWEN   = req_wen[owner];
                    ramREN   = req_ren[owner] & ~req_wen[owner];
                    ramaddr  = req_addr[int'(owner)*32 +: 32];
                    ramstore = req_store[int'(owner)*32 +: 32];
                    if (own_access) begin
                        req_wait[owner] = 1'b0;
                        if (req_lock[owner] && (beat < BW'(BURST - 1))) begin
                            beat_nxt = beat + 1'b1;
                        end else begin
                            state_nxt  = IDLE;
                            rr_ptr_nxt = next_ptr;
                        end
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state  <= IDLE;
            owner  <= '0;
            rr_ptr <= '0;
            beat   <= '0;
        end else begin
            state  <= state_nxt;
            owner  <= owner_nxt;
            rr_ptr <= rr_ptr_nxt;
            beat   <= beat_nxt;
        end
    end

`ifdef RAM_ARB_PERF_EN
    logic [NREQ-1:0][31:0] cnt;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            cnt <= '0;
        end else if (own_access && (cnt[owner] != 32'hFFFF_FFFF)) begin
            cnt[owner] <= cnt[owner] + 32'd1;
        end
    end

    assign grant_cnt = cnt;
`endif
endmodule

// File: tb/tb_ram_port_arbiter.sv
// Bench for ram_port_arbiter: directed vector table, hand sequences, random run vs. a rule-level model.
module tb_ram_port_arbiter;
    import cpu_types_pkg::*;

    localparam int NREQ  = 4;
    localparam int BURST = 2;

    logic              CLK, nRST;
    logic [NREQ-1:0]   req_ren, req_wen, req_lock;
    logic [NREQ*32-1:0] req_addr, req_store;
    word_t             req_load;
    logic [NREQ-1:0]   req_wait;
    logic [1:0]        grant_id;
    logic              grant_vld, arb_err, ramREN, ramWEN;
    word_t             ramaddr, ramstore, ramload;
    ramstate_t         ramstate;
`ifdef RAM_ARB_PERF_EN
    logic [NREQ*32-1:0] grant_cnt;
`endif

    ram_port_arbiter #(.NREQ(NREQ), .BURST(BURST)) dut (
        .CLK(CLK), .nRST(nRST),
        .req_ren(req_ren), .req_wen(req_wen), .req_lock(req_lock),
        .req_addr(req_addr), .req_store(req_store),
        .req_load(req_load), .req_wait(req_wait),
        .grant_id(grant_id), .grant_vld(grant_vld), .arb_err(arb_err),
`ifdef RAM_ARB_PERF_EN
        .grant_cnt(grant_cnt),
`endif
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_inputs();
        req_ren  = '0;
        req_wen  = '0;
        req_lock = '0;
        ramstate = FREE;
        ramload  = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_addr[i*32 +: 32]  = 32'h40 * i;
            req_store[i*32 +: 32] = 32'hA000_0000 + i;
        end
    endtask

    task automatic do_reset();
        clear_inputs();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        step();
    endtask

    typedef struct {
        logic [3:0] ren, wen, lock;
        ramstate_t  rs;
        logic       e_ren, e_wen;
        logic [3:0] e_wait;
        logic [1:0] e_gid;
        logic       e_gvld, e_err;
        word_t      e_addr, e_store;
    } vec_t;

    function automatic vec_t mk(logic [3:0] ren, logic [3:0] wen, logic [3:0] lock, ramstate_t rs,
                                logic er, logic ew, logic [3:0] wt, logic [1:0] gid, logic gv,
                                logic err, word_t a, word_t s);
        vec_t v;
        v.ren = ren; v.wen = wen; v.lock = lock; v.rs = rs;
        v.e_ren = er; v.e_wen = ew; v.e_wait = wt; v.e_gid = gid;
        v.e_gvld = gv; v.e_err = err; v.e_addr = a; v.e_store = s;
        return v;
    endfunction

    // Rule-level reference model state.
    bit          m_busy;
    int          m_own, m_rr, m_beats;
    logic [31:0] m_cnt [NREQ];

    task automatic model_reset();
        m_busy = 0; m_own = 0; m_rr = 0; m_beats = 0;
        for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
    endtask

    task automatic model_check_and_advance();
        bit         act;
        logic [3:0] e_wait;
        act    = m_busy && (req_ren[m_own] || req_wen[m_own]);
        e_wait = 4'hF;
        if (act && ramstate == ACCESS) e_wait[m_own] = 1'b0;
        check("rnd_gvld", grant_vld, m_busy);
        check("rnd_gid", grant_id, m_busy ? m_own : 0);
        check("rnd_wen", ramWEN, act && req_wen[m_own]);
        check("rnd_ren", ramREN, act && req_ren[m_own] && !req_wen[m_own]);
        check("rnd_wait", req_wait, e_wait);
        check("rnd_err", arb_err, m_busy && ramstate == ERROR);
        check("rnd_load", req_load, ramload);
        if (act) begin
            check("rnd_addr", ramaddr, req_addr[m_own*32 +: 32]);
            check("rnd_store", ramstore, req_store[m_own*32 +: 32]);
        end
`ifdef RAM_ARB_PERF_EN
        for (int i = 0; i < NREQ; i++) check("rnd_cnt", grant_cnt[i*32 +: 32], m_cnt[i]);
`endif
        if (!m_busy) begin
            for (int k = 0; k < NREQ; k++) begin
                int j;
                j = (m_rr + k) % NREQ;
                if (req_ren[j] || req_wen[j]) begin
                    m_busy = 1; m_own = j; m_beats = 0;
                    break;
                end
            end
        end else if (!act) begin
            m_busy = 0;
            m_rr   = (m_own + 1) % NREQ;
        end else if (ramstate == ACCESS) begin
            if (m_cnt[m_own] != 32'hFFFF_FFFF) m_cnt[m_own] = m_cnt[m_own] + 1;
            m_beats++;
            if (!(req_lock[m_own] && m_beats < BURST)) begin
                m_busy = 0;
                m_rr   = (m_own + 1) % NREQ;
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t   tbl[$];
        int     got;
        logic [1:0] order [4];

        nRST = 1'b1;
        clear_inputs();
        do_reset();

        #4;
        check("reset_ren", ramREN, 1'b0);
        check("reset_wen", ramWEN, 1'b0);
        check("reset_wait", req_wait, 4'hF);
        check("reset_gvld", grant_vld, 1'b0);
        check("reset_gid", grant_id, 2'd0);
        check("reset_err", arb_err, 1'b0);
        step();

        // Directed cycle-by-cycle table starting from IDLE, rr_ptr=0.
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, FREE,   0, 0, 4'hF, 0, 0, 0, 32'h0,  32'h0));
        tbl.push_back(mk(4'h2, 4'h0, 4'h0, FREE,   0, 0, 4'hF, 0, 0, 0, 32'h0,  32'h0));
        tbl.push_back(mk(4'h2, 4'h0, 4'h0, BUSY,   1, 0, 4'hF, 1, 1, 0, 32'h40, 32'hA000_0001));
        tbl.push_back(mk(4'h2, 4'h0, 4'h0, BUSY,   1, 0, 4'hF, 1, 1, 0, 32'h40, 32'hA000_0001));
        tbl.push_back(mk(4'h2, 4'h0, 4'h0, ACCESS, 1, 0, 4'hD, 1, 1, 0, 32'h40, 32'hA000_0001));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, FREE,   0, 0, 4'hF, 0, 0, 0, 32'h0,  32'h0));
        tbl.push_back(mk(4'h6, 4'h0, 4'h0, FREE,   0, 0, 4'hF, 0, 0, 0, 32'h0,  32'h0));
        tbl.push_back(mk(4'h6, 4'h0, 4'h0, ACCESS, 1, 0, 4'hB, 2, 1, 0, 32'h80, 32'hA000_0002));
        tbl.push_back(mk(4'h8, 4'h8, 4'h0, FREE,   0, 0, 4'hF, 0, 0, 0, 32'h0,  32'h0));
        tbl.push_back(mk(4'h8, 4'h8, 4'h0, BUSY,   0, 1, 4'hF, 3, 1, 0, 32'hC0, 32'hA000_0003));
        tbl.push_back(mk(4'h8, 4'h8, 4'h0, ERROR,  0, 1, 4'hF, 3, 1, 1, 32'hC0, 32'hA000_0003));
        tbl.push_back(mk(4'h8, 4'h8, 4'h0, BUSY,   0, 1, 4'hF, 3, 1, 0, 32'hC0, 32'hA000_0003));
        tbl.push_back(mk(4'h8, 4'h8, 4'h0, ACCESS, 0, 1, 4'h7, 3, 1, 0, 32'hC0, 32'hA000_0003));
        tbl.push_back(mk(4'h1, 4'h0, 4'h0, FREE,   0, 0, 4'hF, 0, 0, 0, 32'h0,  32'h0));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, ACCESS, 0, 0, 4'hF, 0, 1, 0, 32'h0,  32'h0));
        tbl.push_back(mk(4'h1, 4'h0, 4'h0, FREE,   0, 0, 4'hF, 0, 0, 0, 32'h0,  32'h0));
        tbl.push_back(mk(4'h1, 4'h0, 4'h0, ACCESS, 1, 0, 4'hE, 0, 1, 0, 32'h0,  32'hA000_0000));
        tbl.push_back(mk(4'h0, 4'h0, 4'h0, FREE,   0, 0, 4'hF, 0, 0, 0, 32'h0,  32'h0));

        for (int i = 0; i < tbl.size(); i++) begin
            req_ren  = tbl[i].ren;
            req_wen  = tbl[i].wen;
            req_lock = tbl[i].lock;
            ramstate = tbl[i].rs;
            #4;
            check($sformatf("tbl%0d_ren", i), ramREN, tbl[i].e_ren);
            check($sformatf("tbl%0d_wen", i), ramWEN, tbl[i].e_wen);
            check($sformatf("tbl%0d_wait", i), req_wait, tbl[i].e_wait);
            check($sformatf("tbl%0d_gid", i), grant_id, tbl[i].e_gid);
            check($sformatf("tbl%0d_gvld", i), grant_vld, tbl[i].e_gvld);
            check($sformatf("tbl%0d_err", i), arb_err, tbl[i].e_err);
            if (tbl[i].e_ren || tbl[i].e_wen) begin
                check($sformatf("tbl%0d_addr", i), ramaddr, tbl[i].e_addr);
                check($sformatf("tbl%0d_store", i), ramstore, tbl[i].e_store);
            end
            step();
        end

        // Contention: requesters 0,2,3 held from rr_ptr=0.
        do_reset();
        order[0] = 2'd0; order[1] = 2'd2; order[2] = 2'd3; order[3] = 2'd0;
        req_ren  = 4'b1101;
        ramstate = ACCESS;
        got = 0;
        for (int c = 0; c < 20 && got < 4; c++) begin
            #4;
            if (grant_vld && req_wait != 4'hF) begin
                check($sformatf("rr_order%0d", got), grant_id, order[got]);
                got++;
            end
            step();
        end
        check("rr_order_count", got, 4);
        clear_inputs();
        ramstate = ACCESS;

        // Locked two-word write burst on 3 while 0 keeps asking (rr_ptr now 1).
        req_wen  = 4'b1000;
        req_ren  = 4'b0001;
        req_lock = 4'b1000;
        req_addr[3*32 +: 32] = 32'h80;
        #4;
        check("burst_idle_gvld", grant_vld, 1'b0);
        step();
        #4;
        check("burst_b0_gid", grant_id, 2'd3);
        check("burst_b0_wait", req_wait, 4'b0111);
        check("burst_b0_wen", ramWEN, 1'b1);
        check("burst_b0_addr", ramaddr, 32'h80);
        step();
        req_addr[3*32 +: 32] = 32'h84;
        #4;
        check("burst_b1_gid", grant_id, 2'd3);
        check("burst_b1_wait", req_wait, 4'b0111);
        check("burst_b1_addr", ramaddr, 32'h84);
        step();
        #4;
        check("burst_end_gvld", grant_vld, 1'b0);
        step();
        #4;
        check("burst_next_gid", grant_id, 2'd0);
        check("burst_next_wait", req_wait, 4'b1110);
        clear_inputs();
        step();
        step();

        // Asynchronous reset during beat 0 of a locked burst.
        req_wen  = 4'b1000;
        req_lock = 4'b1000;
        ramstate = BUSY;
        step();
        #2;
        check("rst_pre_wen", ramWEN, 1'b1);
        nRST = 1'b0;
        #1;
        check("rst_wen", ramWEN, 1'b0);
        check("rst_ren", ramREN, 1'b0);
        check("rst_wait", req_wait, 4'hF);
        check("rst_gvld", grant_vld, 1'b0);
`ifdef RAM_ARB_PERF_EN
        check("rst_cnt", grant_cnt, '0);
`endif
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;

        // Random traffic against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            req_ren  = NREQ'($urandom & $urandom_range(0, 15));
            req_wen  = NREQ'($urandom & $urandom & $urandom);
            req_lock = NREQ'($urandom);
            ramstate = ramstate_t'($urandom_range(0, 3));
            ramload  = $urandom;
            for (int i = 0; i < NREQ; i++) begin
                req_addr[i*32 +: 32]  = $urandom;
                req_store[i*32 +: 32] = $urandom;
            end
            #4;
            model_check_and_advance();
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
